// File: rtl/rx_operand_assembler_pkg.sv
// Shared framing definitions for the 381-bit adder link. The transmit-side
// serializer uses the same package, so both ends agree on frame geometry.
//   OP_WIDTH    : operand width carried by one frame
//   FRAME_BYTES : bytes per operand frame, MSB byte first
//   PAD_BITS    : zero pad bits at the top of each frame
//   state_t     : receive framing state
package rx_operand_assembler_pkg;

  localparam int OP_WIDTH    = 382;
  localparam int FRAME_BYTES = 48;
  localparam int PAD_BITS    = 2;
  localparam int FRAME_WIDTH = OP_WIDTH + PAD_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV_A = 2'd1,
    RECV_B = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // True when the pad bits of a frame's first (most significant) byte are set.
  function automatic logic pad_bits_set(input logic [7:0] first_byte);
    return |first_byte[7:(8 - PAD_BITS)];
  endfunction

endpackage

// File: rtl/rx_operand_assembler_byte_shift_reg_384.sv
// 384-bit byte-wide shift register holding one operand frame.
// Bytes enter at the bottom and move toward the MSB, so after a full frame
// the first byte received sits in the top byte.
//   clk      : clock
//   reset    : synchronous active-high reset, clears the register
//   clr      : clear; combined with shift_en the result is just byte_in
//   shift_en : shift left by one byte and insert byte_in at [7:0]
//   byte_in  : byte to insert
//   data_out : full frame contents
module byte_shift_reg_384
  import rx_operand_assembler_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   shift_en,
  input  logic [7:0]             byte_in,
  output logic [FRAME_WIDTH-1:0] data_out
);

  logic [FRAME_WIDTH-1:0] data_r;

  // Frame storage: clear, clear-and-load, or shift in one byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= {FRAME_WIDTH{1'b0}};
    end else if (clr && shift_en) begin
      data_r <= {{(FRAME_WIDTH - 8){1'b0}}, byte_in};
    end else if (clr) begin
      data_r <= {FRAME_WIDTH{1'b0}};
    end else if (shift_en) begin
      data_r <= {data_r[FRAME_WIDTH-9:0], byte_in};
    end else begin
      data_r <= data_r;
    end
  end

  assign data_out = data_r;

endmodule

// File: rtl/rx_operand_assembler.sv
// Receive-side framing for the 381-bit adder. Collects two operand frames
// (A then B, each BYTES_PER_OP bytes MSB first) from the UART byte stream and
// presents the pair with a valid/ack handshake.
//   clk, reset  : clock, synchronous active-high reset
//   rx_stb      : one-cycle strobe, rx_byte valid
//   rx_byte     : received byte
//   op_a, op_b  : assembled operands (pad bits stripped), held while valid
//   valid       : operand pair ready, held until ack
//   ack         : consumer took the pair; only looked at while valid
//   pad_err     : a pad bit of A or B was nonzero; meaningful with valid
//   timeout_err : one-cycle pulse, a partial frame was dropped after silence
//   overrun     : sticky, a byte arrived while valid; cleared by ack
module rx_operand_assembler
  import rx_operand_assembler_pkg::*;
#(
  parameter int BYTES_PER_OP   = FRAME_BYTES,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_stb,
  input  logic [7:0]          rx_byte,
  output logic [OP_WIDTH-1:0] op_a,
  output logic [OP_WIDTH-1:0] op_b,
  output logic                valid,
  input  logic                ack,
  output logic                pad_err,
  output logic                timeout_err,
  output logic                overrun
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [5:0]       LAST_BYTE = 6'(BYTES_PER_OP - 1);
  localparam logic [CNT_W-1:0] IDLE_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_r, state_nx_s;
  logic [5:0]       byte_cnt_r, byte_cnt_nx_s;
  logic [CNT_W-1:0] idle_cnt_r, idle_cnt_nx_s;
  logic             pad_r, pad_nx_s;
  logic             valid_r, valid_nx_s;
  logic             overrun_r, overrun_nx_s;
  logic             timeout_r, timeout_nx_s;
  logic             clr_s, shift_a_s, shift_b_s;
  logic [FRAME_WIDTH-1:0] shreg_a_s, shreg_b_s;

  byte_shift_reg_384 u_shreg_a (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr_s),
    .shift_en (shift_a_s),
    .byte_in  (rx_byte),
    .data_out (shreg_a_s)
  );

  byte_shift_reg_384 u_shreg_b (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr_s),
    .shift_en (shift_b_s),
    .byte_in  (rx_byte),
    .data_out (shreg_b_s)
  );

  // Next-state, counters, flags and shift-register controls.
  always_comb begin
    state_nx_s    = state_r;
    byte_cnt_nx_s = byte_cnt_r;
    idle_cnt_nx_s = idle_cnt_r;
    pad_nx_s      = pad_r;
    valid_nx_s    = valid_r;
    overrun_nx_s  = overrun_r;
    timeout_nx_s  = 1'b0;
    clr_s         = 1'b0;
    shift_a_s     = 1'b0;
    shift_b_s     = 1'b0;

    case (state_r)
      IDLE: begin
        valid_nx_s    = 1'b0;
        idle_cnt_nx_s = {CNT_W{1'b0}};
        if (rx_stb) begin
          // Start of a new frame: wipe old data and take the first byte of A.
          clr_s         = 1'b1;
          shift_a_s     = 1'b1;
          pad_nx_s      = pad_bits_set(rx_byte);
          byte_cnt_nx_s = 6'd1;
          state_nx_s    = RECV_A;
        end else begin
          byte_cnt_nx_s = 6'd0;
        end
      end

      RECV_A, RECV_B: begin
        if (rx_stb) begin
          shift_a_s     = (state_r == RECV_A);
          shift_b_s     = (state_r == RECV_B);
          idle_cnt_nx_s = {CNT_W{1'b0}};
          pad_nx_s      = pad_r | ((byte_cnt_r == 6'd0) && pad_bits_set(rx_byte));
          if (byte_cnt_r == LAST_BYTE) begin
            byte_cnt_nx_s = 6'd0;
            if (state_r == RECV_A) begin
              state_nx_s = RECV_B;
            end else begin
              state_nx_s = HOLD;
              valid_nx_s = 1'b1;
            end
          end else begin
            byte_cnt_nx_s = byte_cnt_r + 6'd1;
          end
        end else if (idle_cnt_r == IDLE_TERM) begin
          // Stalled partial frame (even with a complete A) is dropped.
          timeout_nx_s  = 1'b1;
          byte_cnt_nx_s = 6'd0;
          idle_cnt_nx_s = {CNT_W{1'b0}};
          state_nx_s    = IDLE;
        end else begin
          idle_cnt_nx_s = idle_cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
        end
      end

      HOLD: begin
        // The pad bits sit at the top of each held frame; folding them in
        // keeps the flag consistent with what is actually being presented.
        pad_nx_s = pad_r | pad_bits_set(shreg_a_s[FRAME_WIDTH-1 -: 8])
                         | pad_bits_set(shreg_b_s[FRAME_WIDTH-1 -: 8]);
        if (ack) begin
          // A byte arriving with ack is dropped; it never starts a frame.
          valid_nx_s   = 1'b0;
          overrun_nx_s = 1'b0;
          state_nx_s   = IDLE;
        end else if (rx_stb) begin
          overrun_nx_s = 1'b1;
        end else begin
          overrun_nx_s = overrun_r;
        end
      end

      default: begin
        state_nx_s    = IDLE;
        byte_cnt_nx_s = 6'd0;
        idle_cnt_nx_s = {CNT_W{1'b0}};
        valid_nx_s    = 1'b0;
      end
    endcase
  end

  // State and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      byte_cnt_r <= 6'd0;
      idle_cnt_r <= {CNT_W{1'b0}};
      pad_r      <= 1'b0;
      valid_r    <= 1'b0;
      overrun_r  <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      byte_cnt_r <= byte_cnt_nx_s;
      idle_cnt_r <= idle_cnt_nx_s;
      pad_r      <= pad_nx_s;
      valid_r    <= valid_nx_s;
      overrun_r  <= overrun_nx_s;
      timeout_r  <= timeout_nx_s;
    end
  end

  assign op_a        = shreg_a_s[OP_WIDTH-1:0];
  assign op_b        = shreg_b_s[OP_WIDTH-1:0];
  assign valid       = valid_r;
  assign pad_err     = pad_r;
  assign timeout_err = timeout_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_rx_operand_assembler.sv
// Self-checking bench for rx_operand_assembler. Frames are built as byte
// arrays; the expected operands and pad flag are computed from the bytes
// with plain arithmetic.
module tb_rx_operand_assembler;

  localparam int TO = 40;

  logic         clk = 1'b0;
  logic         reset;
  logic         rx_stb;
  logic [7:0]   rx_byte;
  logic         ack;
  logic [381:0] op_a;
  logic [381:0] op_b;
  logic         valid;
  logic         pad_err;
  logic         timeout_err;
  logic         overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int to_seen  = 0;

  logic [7:0]   frm [96];
  logic [383:0] exp_a;
  logic [383:0] exp_b;
  logic         exp_pad;

  rx_operand_assembler #(.BYTES_PER_OP(48), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_stb      (rx_stb),
    .rx_byte     (rx_byte),
    .op_a        (op_a),
    .op_b        (op_b),
    .valid       (valid),
    .ack         (ack),
    .pad_err     (pad_err),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (timeout_err === 1'b1) to_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [383:0] obs, input logic [383:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: operands are the big-endian value of each 48-byte half,
  // reduced to 382 bits; pad error if either first byte has its top two bits set.
  task automatic build_model();
    exp_a = 384'd0;
    exp_b = 384'd0;
    for (int i = 0; i < 48; i++) begin
      exp_a = (exp_a << 8) | 384'(frm[i]);
      exp_b = (exp_b << 8) | 384'(frm[48 + i]);
    end
    exp_a   = exp_a % (384'd1 << 382);
    exp_b   = exp_b % (384'd1 << 382);
    exp_pad = (frm[0] >= 8'h40) || (frm[48] >= 8'h40);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 96; i++) frm[i] = 8'($urandom);
    if ($urandom_range(0, 1) == 0) frm[0]  = frm[0]  & 8'h3F;
    if ($urandom_range(0, 1) == 0) frm[48] = frm[48] & 8'h3F;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rx_stb  = 1'b1;
    rx_byte = b;
    tick();
    rx_stb  = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_op_a"}, 384'(op_a), exp_a);
    check_val({tag, "_op_b"}, 384'(op_b), exp_b);
    check_val({tag, "_pad"}, 384'(pad_err), 384'(exp_pad));
  endtask

  // Sends frm[0..95]; max_gap adds random idle cycles, long_at inserts one
  // gap of TO-1 idle cycles (the longest gap that must not time out).
  task automatic send_frame(input string tag, input int max_gap, input int long_at);
    int g;
    int to_before;
    build_model();
    to_before = to_seen;
    for (int i = 0; i < 96; i++) begin
      g = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
      if (i == long_at) g = TO - 1;
      send_byte(frm[i], g);
      if (i == 94) check_val({tag, "_valid_early"}, 384'(valid), 384'(1'b0));
    end
    check_val({tag, "_valid"}, 384'(valid), 384'(1'b1));
    check_val({tag, "_no_to"}, 384'(to_seen - to_before), 384'(0));
    check_outputs(tag);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_val({tag, "_ack_valid"}, 384'(valid), 384'(1'b0));
    check_val({tag, "_ack_ovr"}, 384'(overrun), 384'(1'b0));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_op_a"}, 384'(op_a), 384'd0);
    check_val({tag, "_op_b"}, 384'(op_b), 384'd0);
    check_val({tag, "_flags"}, 384'({valid, pad_err, timeout_err, overrun}), 384'd0);
  endtask

  initial begin
    int early;
    int to_before;
    reset   = 1'b1;
    rx_stb  = 1'b0;
    rx_byte = 8'h00;
    ack     = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check_zero("rst");

    // A = 1, B = all ones, back-to-back strobes.
    for (int i = 0; i < 96; i++) frm[i] = 8'h00;
    frm[47] = 8'h01;
    frm[48] = 8'h3F;
    for (int i = 49; i < 96; i++) frm[i] = 8'hFF;
    send_frame("ones", 0, -1);
    check_val("ones_exp_b", 384'(op_b), {2'b00, {382{1'b1}}});
    do_ack("ones");

    // Pad bits set in A's first byte.
    for (int i = 0; i < 96; i++) frm[i] = 8'h00;
    frm[0] = 8'hC5;
    send_frame("pad", 0, -1);
    check_val("pad_top", 384'(op_a[381:376]), 384'(6'h05));
    check_val("pad_flag", 384'(pad_err), 384'(1'b1));
    do_ack("pad");

    // 20 bytes then silence: exactly one pulse, TO+1 cycles after the last strobe.
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), 0);
    early = 0;
    for (int i = 0; i < TO; i++) begin
      if (timeout_err !== 1'b0) early = 1;
      tick();
    end
    check_val("to_early", 384'(early), 384'(0));
    check_val("to_pulse", 384'(timeout_err), 384'(1'b1));
    tick();
    check_val("to_pulse_end", 384'(timeout_err), 384'(1'b0));
    check_val("to_valid", 384'(valid), 384'(1'b0));
    fill_random();
    send_frame("after_to", 2, -1);
    do_ack("after_to");

    // Overrun: bytes during HOLD are dropped and flagged; long hold never times out.
    fill_random();
    send_frame("ovr", 0, -1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    check_val("ovr_flag", 384'(overrun), 384'(1'b1));
    check_val("ovr_valid", 384'(valid), 384'(1'b1));
    check_outputs("ovr_held");
    to_before = to_seen;
    repeat (TO + 5) tick();
    check_val("hold_no_to", 384'(to_seen - to_before), 384'(0));
    check_val("hold_valid", 384'(valid), 384'(1'b1));
    check_val("hold_ovr", 384'(overrun), 384'(1'b1));
    do_ack("ovr");

    // ack and a strobe in the same HOLD cycle: the byte is dropped.
    fill_random();
    send_frame("ackstb", 1, -1);
    ack     = 1'b1;
    rx_stb  = 1'b1;
    rx_byte = 8'($urandom);
    tick();
    ack     = 1'b0;
    rx_stb  = 1'b0;
    check_val("ackstb_valid", 384'(valid), 384'(1'b0));
    check_val("ackstb_ovr", 384'(overrun), 384'(1'b0));
    fill_random();
    send_frame("ackstb_next", 0, -1);
    do_ack("ackstb_next");

    // Reset mid-frame, then a known frame.
    to_before = to_seen;
    for (int i = 0; i < 50; i++) send_byte(8'($urandom), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("midrst");
    check_val("midrst_no_to", 384'(to_seen - to_before), 384'(0));
    for (int i = 0; i < 48; i++) begin
      frm[i]      = 8'(i + 1);
      frm[48 + i] = 8'hAA;
    end
    send_frame("known", 0, -1);
    do_ack("known");

    // Random frames with random gaps, one maximal gap and random ack delay.
    for (int k = 0; k < 4; k++) begin
      fill_random();
      send_frame($sformatf("rnd%0d", k), 3, int'($urandom_range(1, 95)));
      repeat ($urandom_range(0, 5)) tick();
      check_val($sformatf("rnd%0d_hold", k), 384'(valid), 384'(1'b1));
      do_ack($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_operand_assembler.md
# rx_operand_assembler

Receive-side framing stage for the 381-bit adder. It consumes the byte stream from the UART receiver and assembles two 382-bit operands, A then B, each sent as 48 bytes MSB-byte first. Each operand is a 384-bit frame whose top 2 bits are zero pad, which mirrors the transmit-side serializer's format. The operand pair is presented to the adder with a valid/ack handshake, plus error flags for bad pad bits, stalled frames and overrun.

## Interface
Parameters:
- BYTES_PER_OP, 48, bytes per operand frame (384 bits).
- TIMEOUT_CYCLES, 1_000_000, idle clocks between bytes of a partial frame before it is discarded.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- rx_stb  in  1  one-cycle strobe: rx_byte is valid.
- rx_byte  in  8  received byte.
- op_a  out  382  operand A, held while valid.
- op_b  out  382  operand B, held while valid.
- valid  out  1  operand pair complete; level, held until ack.
- ack  in  1  consumer has taken op_a/op_b; sampled only while valid.
- pad_err  out  1  a pad bit (frame bit 383 or 382) of A or B was nonzero; qualified by valid.
- timeout_err  out  1  one-cycle pulse: a partial frame was discarded.
- overrun  out  1  sticky: a byte arrived while valid was high; cleared on ack.

## Operation
- States: IDLE, RECV_A, RECV_B, HOLD.
- IDLE:
  - On rx_stb: clear both shift registers and the pad flag, shift the byte in, set byte_cnt=1, go to RECV_A.
- RECV_A / RECV_B, on each rx_stb:
  - Shift the current 384-bit register left by 8 and insert rx_byte at bits [7:0].
  - Increment byte_cnt.
  - Reset the idle counter.
- Pad check: the first byte of each operand (byte_cnt==0 within that operand) has rx_byte[7:6] checked; if nonzero, set the pad flag.
- Operand boundaries:
  - When the 48th byte of A is taken: byte_cnt←0, go to RECV_B.
  - When the 48th byte of B is taken: go to HOLD.
- op_a = shreg_a[381:0], op_b = shreg_b[381:0]; pad bits are never forwarded.
- Timeout:
  - In RECV_A/RECV_B, the idle counter increments every cycle without rx_stb.
  - When it reaches TIMEOUT_CYCLES-1: pulse timeout_err, byte_cnt←0, go to IDLE.
  - The partial frame is lost, including a completed A.
- HOLD:
  - valid=1.
  - rx_stb is dropped and sets overrun. Registers are unchanged.
  - On ack: valid←0, overrun←0, go to IDLE.
- Simultaneous ack and rx_stb in HOLD: the byte is dropped (it does not start a new frame), and ack clears overrun.
- byte_cnt is 6 bits and never exceeds 47; no wrap.

## Timing
- Reset values: op_a=0, op_b=0, valid=0, pad_err=0, timeout_err=0, overrun=0. State=IDLE, counters=0.
- Reset mid-frame discards all partial data; no error pulse.
- Latency:
  - valid rises on the clock edge after the 96th rx_stb cycle.
  - op_a, op_b and pad_err are stable from that cycle until ack.
- valid falls the cycle after ack is sampled high. The earliest next frame byte is accepted the cycle after that (IDLE).
- rx_stb at most once per cycle; back-to-back strobes are accepted in every cycle.
- timeout_err is high for exactly 1 cycle, the cycle after the terminal count.

## Structure
- Shared package, also used by the transmit-side serializer:
  - OP_WIDTH=382, FRAME_BYTES=48, PAD_BITS=2.
  - State enum {IDLE, RECV_A, RECV_B, HOLD}.
- One sub-module: byte_shift_reg_384 (clear, shift-in-byte, 384-bit parallel out), instantiated twice for A and B.
- Timeout counter and FSM stay in the top.

## Test plan
- A = 382'h1 (47×0x00, 0x01), B = 2^382−1 (0x3F, 47×0xFF), back-to-back strobes -> valid 1 cycle after the 96th strobe; op_a=1, op_b=all ones; pad_err=0.
- A first byte 0xC5, remaining bytes 0x00; B all zero -> valid with pad_err=1; op_a[381:376]=6'h05.
- 20 bytes, then silence for TIMEOUT_CYCLES -> one timeout_err pulse, state IDLE. A following clean 96-byte frame decodes correctly.
- Full frame, then 3 bytes while valid -> overrun=1, op_a/op_b unchanged. ack -> valid=0, overrun=0 next cycle.
- ack and rx_stb in the same HOLD cycle -> byte dropped. The next frame starts only with the following strobe and decodes correctly.
- reset after 50 bytes -> all outputs 0. A subsequent 96-byte frame A=0x0102…, B=0xAA… decodes exactly.
